// File: rtl/keyarb_pkg.sv
// Shared types and constants for the key arbiter: injector states, lock
// owner encoding, scancode prefix bytes and wait-counter width.
package keyarb_pkg;

  localparam int CNT_W = 20;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [2:0] {
    IDLE,
    MK_PFX,
    MK_CODE,
    HOLD,
    BK_PFX,
    BK_F0,
    BK_CODE,
    GAP
  } inj_state_t;

  typedef enum logic [1:0] {
    LOCK_NONE,
    LOCK_PS2,
    LOCK_INJ
  } lock_t;

  // Only E0 and F0 continue a sequence; every other byte (E1 included) ends it.
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PFX_EXT) || (b == PFX_BRK);
  endfunction

endpackage

// File: rtl/key_arbiter_if.sv
// Handshake bundle between the PS/2 receiver, the key injector and the
// keyboard-matrix side of the arbiter.
interface key_arbiter_if;
  logic       ps2_strb;
  logic [7:0] ps2_code;
  logic       inj_valid;
  logic [7:0] inj_code;
  logic       inj_ext;
  logic       inj_ready;
  logic       strb;
  logic [7:0] code;
  logic       ovf;

  // Source side: drives PS/2 bytes and injector requests.
  modport master (
    output ps2_strb, ps2_code, inj_valid, inj_code, inj_ext,
    input  inj_ready, strb, code, ovf
  );

  // Arbiter side.
  modport slave (
    input  ps2_strb, ps2_code, inj_valid, inj_code, inj_ext,
    output inj_ready, strb, code, ovf
  );
endinterface

// File: rtl/key_fifo.sv
// Small power-of-two byte FIFO buffering PS/2 scancodes. A write while full
// is still taken when a read happens in the same cycle.
module key_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_do_wr;
  logic              w_do_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array, data only.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/key_arbiter.sv
// Merges PS/2 scancodes and injected make/break sequences into a single
// strobed byte stream for the keyboard matrix. A lock keeps prefixed
// sequences (E0 xx, F0 xx, E0 F0 xx) from one source contiguous.
module key_arbiter
  import keyarb_pkg::*;
#(
  parameter int HOLD_CYCLES = 200000,
  parameter int GAP_CYCLES  = 200000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic         clock,
  input  logic         reset,
  key_arbiter_if.slave bus
);
  // Make-to-break spacing is measured strobe to strobe; the break's first
  // emit cycle completes the interval, so the wait state spans one fewer.
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 1) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(1);
  // Gap is measured from the final break strobe to inj_ready rising.
  localparam logic [CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 1) ? CNT_W'(GAP_CYCLES) : CNT_W'(1);

  inj_state_t       r_state;
  lock_t            r_lock;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_code_lat;
  logic             r_ext_lat;
  logic             r_inj_ready;
  logic             r_strb;
  logic [7:0]       r_code;
  logic             r_ovf;

  logic [7:0]       w_fifo_rdata;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_fifo_req;
  logic             w_fifo_gnt;
  logic             w_inj_req;
  logic             w_inj_gnt;
  logic [7:0]       w_inj_byte;
  logic             w_emit;
  logic [7:0]       w_emit_byte;
  logic             w_drop;

  key_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_wr    (bus.ps2_strb),
    .i_wdata (bus.ps2_code),
    .i_rd    (w_fifo_gnt),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_drop = bus.ps2_strb && w_fifo_full && !w_fifo_gnt;

  // Pick the byte the injector wants to send now and decide who emits.
  // In IDLE a valid request bids with its first byte so an accepted
  // injection reaches the matrix on the very next cycle.
  always_comb begin
    w_inj_req  = 1'b0;
    w_inj_byte = r_code_lat;
    case (r_state)
      IDLE: begin
        w_inj_req  = bus.inj_valid;
        w_inj_byte = bus.inj_ext ? PFX_EXT : bus.inj_code;
      end
      MK_PFX, BK_PFX: begin
        w_inj_req  = 1'b1;
        w_inj_byte = PFX_EXT;
      end
      MK_CODE, BK_CODE: begin
        w_inj_req  = 1'b1;
        w_inj_byte = r_code_lat;
      end
      BK_F0: begin
        w_inj_req  = 1'b1;
        w_inj_byte = PFX_BRK;
      end
      default: ;
    endcase

    w_fifo_req  = !w_fifo_empty;
    w_fifo_gnt  = w_fifo_req && (r_lock != LOCK_INJ);
    w_inj_gnt   = w_inj_req &&
                  ((r_lock == LOCK_INJ) || ((r_lock == LOCK_NONE) && !w_fifo_req));
    w_emit      = w_fifo_gnt || w_inj_gnt;
    w_emit_byte = w_fifo_gnt ? w_fifo_rdata : w_inj_byte;
  end

  // Registered matrix strobe/byte, sequence lock and sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_strb <= 1'b0;
      r_code <= 8'h00;
      r_lock <= LOCK_NONE;
      r_ovf  <= 1'b0;
    end else begin
      r_strb <= w_emit;
      if (w_emit) begin
        r_code <= w_emit_byte;
        if (is_prefix(w_emit_byte))
          r_lock <= w_fifo_gnt ? LOCK_PS2 : LOCK_INJ;
        else
          r_lock <= LOCK_NONE;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Capture the injected key at accept; later input changes are ignored.
  always_ff @(posedge clock) begin
    if ((r_state == IDLE) && bus.inj_valid) begin
      r_code_lat <= bus.inj_code;
      r_ext_lat  <= bus.inj_ext;
    end
  end

  // Injector sequencer: make, hold, break, gap. Emit states advance only
  // on a won arbitration; wait states count down a counter loaded on entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_inj_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.inj_valid) begin
            r_inj_ready <= 1'b0;
            if (w_inj_gnt) begin
              if (bus.inj_ext) begin
                r_state <= MK_CODE;
              end else begin
                r_state <= HOLD;
                r_cnt   <= HOLD_LOAD;
              end
            end else begin
              r_state <= bus.inj_ext ? MK_PFX : MK_CODE;
            end
          end
        end
        MK_PFX: begin
          if (w_inj_gnt) r_state <= MK_CODE;
        end
        MK_CODE: begin
          if (w_inj_gnt) begin
            r_state <= HOLD;
            r_cnt   <= HOLD_LOAD;
          end
        end
        HOLD: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= r_ext_lat ? BK_PFX : BK_F0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        BK_PFX: begin
          if (w_inj_gnt) r_state <= BK_F0;
        end
        BK_F0: begin
          if (w_inj_gnt) r_state <= BK_CODE;
        end
        BK_CODE: begin
          if (w_inj_gnt) begin
            r_state <= GAP;
            r_cnt   <= GAP_LOAD;
          end
        end
        GAP: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_cnt       <= '0;
            r_state     <= IDLE;
            r_inj_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_inj_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.inj_ready = r_inj_ready;
  assign bus.strb      = r_strb;
  assign bus.code      = r_code;
  assign bus.ovf       = r_ovf;

endmodule
